// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types and constants for the 5-stage pipeline hazard controller.
package pipeline_hazard_ctrl_pkg;

   localparam int unsigned REG_W = 5;

   typedef logic [REG_W-1:0] reg_idx_t;
   typedef logic [1:0]       fwd_sel_t;

   typedef enum logic [1:0] {
      StInit    = 2'd0,
      StRun     = 2'd1,
      StLdstall = 2'd2,
      StMemwait = 2'd3
   } state_e;

   localparam fwd_sel_t FWD_RF  = 2'b00;
   localparam fwd_sel_t FWD_EX  = 2'b01;
   localparam fwd_sel_t FWD_MEM = 2'b10;
   localparam fwd_sel_t FWD_WB  = 2'b11;

   // %g0 is hardwired to zero, so a source of r0 never matches a producer.
   function automatic logic src_hit(logic used, reg_idx_t src, reg_idx_t rd);
      return used && (src != '0) && (src == rd);
   endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Pipeline-side signals of the hazard controller; master is the controller.
interface pipeline_hazard_ctrl_if #(
   parameter int unsigned CNT_W = 16
);
   import pipeline_hazard_ctrl_pkg::*;

   reg_idx_t          id_rs1;
   reg_idx_t          id_rs2;
   reg_idx_t          id_rd;
   logic              id_use_rs1;
   logic              id_use_rs2;
   logic              id_use_rd;
   logic              id_branch;
   logic              id_annul;
   reg_idx_t          ex_rd;
   reg_idx_t          mem_rd;
   reg_idx_t          wb_rd;
   logic              ex_we;
   logic              mem_we;
   logic              wb_we;
   logic              ex_is_load;
   logic              mem_busy;

   logic              pc_le;
   logic              npc_le;
   logic              if_id_le;
   logic              if_id_clr;
   logic              id_ex_clr;
   logic              ex_mem_clr;
   logic              mem_wb_clr;
   logic              pipe_hold;
   fwd_sel_t          fwd_mx1;
   fwd_sel_t          fwd_mx2;
   fwd_sel_t          fwd_mx3;
   logic [CNT_W-1:0]  stall_cnt;
   logic              mem_timeout_err;

   modport master (
      input  id_rs1, id_rs2, id_rd, id_use_rs1, id_use_rs2, id_use_rd,
      input  id_branch, id_annul, ex_rd, mem_rd, wb_rd, ex_we, mem_we, wb_we,
      input  ex_is_load, mem_busy,
      output pc_le, npc_le, if_id_le, if_id_clr, id_ex_clr, ex_mem_clr, mem_wb_clr,
      output pipe_hold, fwd_mx1, fwd_mx2, fwd_mx3, stall_cnt, mem_timeout_err
   );

   modport slave (
      output id_rs1, id_rs2, id_rd, id_use_rs1, id_use_rs2, id_use_rd,
      output id_branch, id_annul, ex_rd, mem_rd, wb_rd, ex_we, mem_we, wb_we,
      output ex_is_load, mem_busy,
      input  pc_le, npc_le, if_id_le, if_id_clr, id_ex_clr, ex_mem_clr, mem_wb_clr,
      input  pipe_hold, fwd_mx1, fwd_mx2, fwd_mx3, stall_cnt, mem_timeout_err
   );

endinterface

// File: rtl/pipeline_hazard_ctrl_fwd_select.sv
// Operand forwarding select for one ID source register; nearest producing stage wins.
module pipeline_hazard_ctrl_fwd_select
   import pipeline_hazard_ctrl_pkg::*;
(
   input  logic     use_src,
   input  reg_idx_t src,
   input  reg_idx_t ex_rd,
   input  logic     ex_we,
   input  logic     ex_is_load,
   input  reg_idx_t mem_rd,
   input  logic     mem_we,
   input  reg_idx_t wb_rd,
   input  logic     wb_we,
   output fwd_sel_t sel
);

   // A load in EX has no data yet; the load-use stall moves it to MEM first.
   always_comb begin
      sel = FWD_RF;
      if (src_hit(use_src, src, ex_rd) && ex_we && !ex_is_load) begin
         sel = FWD_EX;
      end else if (src_hit(use_src, src, mem_rd) && mem_we) begin
         sel = FWD_MEM;
      end else if (src_hit(use_src, src, wb_rd) && wb_we) begin
         sel = FWD_WB;
      end
   end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline sequencer: post-reset flush, load-use bubbles, memory-wait freeze,
// delay-slot annul and operand forwarding selects.
module pipeline_hazard_ctrl
   import pipeline_hazard_ctrl_pkg::*;
#(
   parameter int unsigned INIT_FLUSH_CYC = 3,
   parameter int unsigned MEM_TIMEOUT    = 64,
   parameter int unsigned CNT_W          = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   pipeline_hazard_ctrl_if.master bus
);

   localparam int unsigned INIT_W = $clog2(INIT_FLUSH_CYC + 1);
   localparam int unsigned MEM_W  = $clog2(MEM_TIMEOUT + 1);

   state_e            state_q, state_d;
   logic [INIT_W-1:0] init_cnt_q;
   logic [MEM_W-1:0]  mem_cnt_q;
   logic [CNT_W-1:0]  stall_cnt_q;
   logic              err_q;

   logic     load_use;
   logic     pc_le, if_id_le, if_id_clr, id_ex_clr, ex_mem_clr, mem_wb_clr, pipe_hold;
   fwd_sel_t fwd1, fwd2, fwd3;

   assign load_use = bus.ex_is_load && bus.ex_we &&
                     (src_hit(bus.id_use_rs1, bus.id_rs1, bus.ex_rd) ||
                      src_hit(bus.id_use_rs2, bus.id_rs2, bus.ex_rd) ||
                      src_hit(bus.id_use_rd,  bus.id_rd,  bus.ex_rd));

   always_comb begin
      state_d    = state_q;
      pc_le      = 1'b0;
      if_id_le   = 1'b0;
      if_id_clr  = 1'b0;
      id_ex_clr  = 1'b0;
      ex_mem_clr = 1'b0;
      mem_wb_clr = 1'b0;
      pipe_hold  = 1'b0;
      unique case (state_q)
         StInit: begin
            if_id_clr  = 1'b1;
            id_ex_clr  = 1'b1;
            ex_mem_clr = 1'b1;
            mem_wb_clr = 1'b1;
            if (init_cnt_q >= INIT_W'(INIT_FLUSH_CYC - 1)) begin
               state_d = StRun;
            end
         end
         StRun, StLdstall, StMemwait: begin
            // After a bubble EX holds the bubble, so load-use is not rechecked.
            if (bus.mem_busy) begin
               pipe_hold = 1'b1;
               state_d   = StMemwait;
            end else if (load_use && (state_q != StLdstall)) begin
               id_ex_clr = 1'b1;
               state_d   = StLdstall;
            end else begin
               pc_le     = 1'b1;
               if_id_le  = 1'b1;
               if_id_clr = bus.id_branch && bus.id_annul;
               state_d   = StRun;
            end
         end
         default: state_d = StInit;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= StInit;
         init_cnt_q  <= '0;
         mem_cnt_q   <= '0;
         stall_cnt_q <= '0;
         err_q       <= 1'b0;
      end else begin
         state_q    <= state_d;
         init_cnt_q <= (state_q == StInit) ? init_cnt_q + 1'b1 : '0;
         // Counts consecutive busy cycles, including the one that entered the freeze.
         if ((state_q != StInit) && bus.mem_busy) begin
            if (mem_cnt_q != MEM_W'(MEM_TIMEOUT)) begin
               mem_cnt_q <= mem_cnt_q + 1'b1;
            end
            if (mem_cnt_q >= MEM_W'(MEM_TIMEOUT - 1)) begin
               err_q <= 1'b1;
            end
         end else begin
            mem_cnt_q <= '0;
         end
         if ((state_q != StInit) && !pc_le && (stall_cnt_q != '1)) begin
            stall_cnt_q <= stall_cnt_q + 1'b1;
         end
      end
   end

   pipeline_hazard_ctrl_fwd_select u_fwd_mx1 (
      .use_src    (bus.id_use_rs1),
      .src        (bus.id_rs1),
      .ex_rd      (bus.ex_rd),
      .ex_we      (bus.ex_we),
      .ex_is_load (bus.ex_is_load),
      .mem_rd     (bus.mem_rd),
      .mem_we     (bus.mem_we),
      .wb_rd      (bus.wb_rd),
      .wb_we      (bus.wb_we),
      .sel        (fwd1)
   );

   pipeline_hazard_ctrl_fwd_select u_fwd_mx2 (
      .use_src    (bus.id_use_rs2),
      .src        (bus.id_rs2),
      .ex_rd      (bus.ex_rd),
      .ex_we      (bus.ex_we),
      .ex_is_load (bus.ex_is_load),
      .mem_rd     (bus.mem_rd),
      .mem_we     (bus.mem_we),
      .wb_rd      (bus.wb_rd),
      .wb_we      (bus.wb_we),
      .sel        (fwd2)
   );

   pipeline_hazard_ctrl_fwd_select u_fwd_mx3 (
      .use_src    (bus.id_use_rd),
      .src        (bus.id_rd),
      .ex_rd      (bus.ex_rd),
      .ex_we      (bus.ex_we),
      .ex_is_load (bus.ex_is_load),
      .mem_rd     (bus.mem_rd),
      .mem_we     (bus.mem_we),
      .wb_rd      (bus.wb_rd),
      .wb_we      (bus.wb_we),
      .sel        (fwd3)
   );

   // The pipeline is being flushed in INIT, so the operand muxes stay on the regfile.
   assign bus.fwd_mx1         = (state_q == StInit) ? FWD_RF : fwd1;
   assign bus.fwd_mx2         = (state_q == StInit) ? FWD_RF : fwd2;
   assign bus.fwd_mx3         = (state_q == StInit) ? FWD_RF : fwd3;
   assign bus.pc_le           = pc_le;
   assign bus.npc_le          = pc_le;
   assign bus.if_id_le        = if_id_le;
   assign bus.if_id_clr       = if_id_clr;
   assign bus.id_ex_clr       = id_ex_clr;
   assign bus.ex_mem_clr      = ex_mem_clr;
   assign bus.mem_wb_clr      = mem_wb_clr;
   assign bus.pipe_hold       = pipe_hold;
   assign bus.stall_cnt       = stall_cnt_q;
   assign bus.mem_timeout_err = err_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Randomized scoreboard bench for pipeline_hazard_ctrl against a behavioural model.
module tb_pipeline_hazard_ctrl;
   import pipeline_hazard_ctrl_pkg::*;

   localparam int unsigned INIT_FLUSH_CYC = 3;
   localparam int unsigned MEM_TIMEOUT    = 64;
   localparam int unsigned CNT_W          = 8;
   localparam int          STALL_MAX      = (1 << CNT_W) - 1;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   pipeline_hazard_ctrl_if #(.CNT_W(CNT_W)) bus ();

   pipeline_hazard_ctrl #(
      .INIT_FLUSH_CYC (INIT_FLUSH_CYC),
      .MEM_TIMEOUT    (MEM_TIMEOUT),
      .CNT_W          (CNT_W)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct packed {
      logic [7:0]       ctl;
      logic [5:0]       fwd;
      logic [CNT_W-1:0] stall;
      logic             err;
   } exp_t;

   exp_t sb_q[$];
   int   checks = 0;
   int   fails  = 0;

   // Model: cycles of flush left, whether last cycle inserted a bubble,
   // consecutive busy cycles, stall cycles seen, sticky timeout.
   int init_left    = INIT_FLUSH_CYC;
   bit after_bubble = 1'b0;
   int busy_run     = 0;
   int stalls       = 0;
   bit err_m        = 1'b0;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         fails++;
         $display("FAIL %s t=%0t got=%h exp=%h", name, $time, got, want);
      end
   endtask

   function automatic logic [1:0] fwd_model(logic use_s, logic [4:0] s, logic [14:0] rds,
                                            logic [2:0] ok);
      if (!use_s || s == 5'd0) return 2'd0;
      for (int i = 0; i < 3; i++) begin
         if (ok[i] && rds[i*5 +: 5] == s) return 2'(i + 1);
      end
      return 2'd0;
   endfunction

   // busy_mode: 0 random, 1 forced high, 2 forced low
   task automatic step(input int busy_mode, input logic rst);
      exp_t       e;
      logic       lu;
      logic [14:0] rds;
      logic [2:0] ok;
      reset          = rst;
      bus.id_rs1     = 5'($urandom_range(0, 3));
      bus.id_rs2     = 5'($urandom_range(0, 3));
      bus.id_rd      = 5'($urandom_range(0, 3));
      bus.id_use_rs1 = ($urandom_range(0, 3) != 0);
      bus.id_use_rs2 = ($urandom_range(0, 3) != 0);
      bus.id_use_rd  = ($urandom_range(0, 3) == 0);
      bus.id_branch  = ($urandom_range(0, 3) == 0);
      bus.id_annul   = ($urandom_range(0, 1) == 0);
      bus.ex_rd      = 5'($urandom_range(0, 3));
      bus.mem_rd     = 5'($urandom_range(0, 3));
      bus.wb_rd      = 5'($urandom_range(0, 3));
      bus.ex_we      = ($urandom_range(0, 3) != 0);
      bus.mem_we     = ($urandom_range(0, 3) != 0);
      bus.wb_we      = ($urandom_range(0, 3) != 0);
      bus.ex_is_load = ($urandom_range(0, 2) == 0);
      bus.mem_busy   = (busy_mode == 1) ? 1'b1 :
                       (busy_mode == 2) ? 1'b0 : ($urandom_range(0, 9) == 0);

      lu = bus.ex_is_load && bus.ex_we && bus.ex_rd != 5'd0 &&
           ((bus.id_use_rs1 && bus.id_rs1 == bus.ex_rd) ||
            (bus.id_use_rs2 && bus.id_rs2 == bus.ex_rd) ||
            (bus.id_use_rd  && bus.id_rd  == bus.ex_rd));
      rds = {bus.wb_rd, bus.mem_rd, bus.ex_rd};
      ok  = {bus.wb_we, bus.mem_we, bus.ex_we && !bus.ex_is_load};

      // ctl = {pc, npc, if_id_le, if_id_clr, id_ex_clr, ex_mem_clr, mem_wb_clr, hold}
      if (init_left > 0)        e.ctl = 8'b0001_1110;
      else if (bus.mem_busy)    e.ctl = 8'b0000_0001;
      else if (lu && !after_bubble) e.ctl = 8'b0000_1000;
      else e.ctl = {3'b111, bus.id_branch && bus.id_annul, 4'b0000};
      if (init_left > 0) e.fwd = 6'd0;
      else e.fwd = {fwd_model(bus.id_use_rs1, bus.id_rs1, rds, ok),
                    fwd_model(bus.id_use_rs2, bus.id_rs2, rds, ok),
                    fwd_model(bus.id_use_rd,  bus.id_rd,  rds, ok)};
      e.stall = CNT_W'(stalls);
      e.err   = err_m;
      sb_q.push_back(e);

      if (rst) begin
         init_left = INIT_FLUSH_CYC; after_bubble = 0; busy_run = 0; stalls = 0; err_m = 0;
      end else if (init_left > 0) begin
         init_left--; after_bubble = 0; busy_run = 0;
      end else begin
         if (!e.ctl[7] && stalls < STALL_MAX) stalls++;
         if (bus.mem_busy) begin
            busy_run++;
            if (busy_run >= MEM_TIMEOUT) err_m = 1'b1;
         end else begin
            busy_run = 0;
         end
         after_bubble = e.ctl[3];
      end
      @(posedge clk);
      #1;
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk("ctl", 32'({bus.pc_le, bus.npc_le, bus.if_id_le, bus.if_id_clr, bus.id_ex_clr,
                            bus.ex_mem_clr, bus.mem_wb_clr, bus.pipe_hold}), 32'(e.ctl));
            chk("fwd", 32'({bus.fwd_mx1, bus.fwd_mx2, bus.fwd_mx3}), 32'(e.fwd));
            chk("stall_cnt", 32'(bus.stall_cnt), 32'(e.stall));
            chk("timeout_err", 32'(bus.mem_timeout_err), 32'(e.err));
         end
      end
   end

   initial begin : driver
      reset = 1'b1;
      bus.mem_busy = 1'b0;
      @(posedge clk);
      #1;
      for (int i = 0; i < 300; i++) step(0, 1'b0);
      for (int i = 0; i < 70; i++)  step(1, 1'b0);
      for (int i = 0; i < 50; i++)  step(0, 1'b0);
      for (int i = 0; i < 200; i++) step(1, 1'b0);
      for (int i = 0; i < 5; i++)   step(2, 1'b0);
      for (int i = 0; i < 20; i++)  step(1, 1'b0);
      step(1, 1'b1);
      for (int i = 0; i < 300; i++) step(0, 1'b0);
      @(negedge clk);
      @(negedge clk);
      chk("scoreboard_drain", 32'(sb_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end

endmodule
